uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: 8-bit UART frame transmitter sequenced by an external
// oversampling baud_tick enable. One start bit, eight data bits LSB first,
// optional parity bit, STOP_BITS stop bits. All outputs are registered.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state inserted after DATA; parity bit = ^data ^ PARITY_ODD
//   undefined -> DATA goes straight to STOP; PARITY_ODD has no effect
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | driving the start bit (low)
// DATA   | driving data bit bit_idx (0..7), LSB first
// PARITY | driving the parity bit (UART_TX_PARITY_EN only)
// STOP   | driving stop bit bit_idx (0..STOP_BITS-1), line high

module uart_tx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  // Last tick index of a bit and last stop-bit index, sized to their counters.
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  // Parameter legality is checked at elaboration so a bad build never produces a netlist.
  if (OVERSAMPLE < 2 || OVERSAMPLE > 16 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx_sequencer: illegal parameter combination");
  end

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_reg;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  // Parity covers the held byte, so it is stable for the whole frame.
  assign parity_bit = (^data_reg) ^ PARITY_ODD[0];
`endif

  // Frame sequencer: handshake, per-bit tick counting and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      data_reg   <= 8'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_ready   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // A baud_tick on this edge is deliberately ignored: the start bit
          // gets its full OVERSAMPLE ticks counted from the next tick onward.
          if (tx_valid && tx_ready) begin
            data_reg <= tx_data;
            state    <= START;
            tx       <= 1'b0;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end
        end
        START, DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP: begin
          if (baud_tick) begin
            if (tick_cnt != TICK_LAST) begin
              tick_cnt <= tick_cnt + 4'd1;
            end else begin
              tick_cnt <= 4'd0;
              case (state)
                START: begin
                  state   <= DATA;
                  bit_idx <= 3'd0;
                  tx      <= data_reg[0];
                end
                DATA: begin
                  if (bit_idx == 3'd7) begin
                    bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                    state   <= PARITY;
                    tx      <= parity_bit;
`else
                    state   <= STOP;
                    tx      <= 1'b1;
`endif
                  end else begin
                    bit_idx <= bit_idx + 3'd1;
                    tx      <= data_reg[bit_idx + 3'd1];
                  end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                  state   <= STOP;
                  bit_idx <= 3'd0;
                  tx      <= 1'b1;
                end
`endif
                STOP: begin
                  if (bit_idx == STOP_LAST) begin
                    state      <= IDLE;
                    bit_idx    <= 3'd0;
                    busy       <= 1'b0;
                    tx_ready   <= 1'b1;
                    frame_done <= 1'b1;
                  end else begin
                    bit_idx <= bit_idx + 3'd1;
                  end
                end
                default: begin
                  state    <= IDLE;
                  tx       <= 1'b1;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= 4'd0;
          bit_idx  <= 3'd0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: two instances (default 16x/1 stop and 8x/2 stop)
// share stimulus; a tick-count frame model predicts every output each cycle.

module tb_uart_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] tx_ready_v, tx_v, busy_v, done_v;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer u_dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0])
  );

  uart_tx_sequencer #(.OVERSAMPLE(8), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1])
  );

`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a frame is a run of ticks ----------------
  function automatic int os_of(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int frame_ticks(input int i);
    return (1 + 8 + PBITS + sb_of(i)) * os_of(i);
  endfunction

  bit         m_active[2];
  bit         m_done[2];
  int         m_cnt[2];
  logic [7:0] m_byte[2];

  function automatic logic exp_tx(input int i);
    int b;
    if (!m_active[i]) return 1'b1;
    b = m_cnt[i] / os_of(i);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[i][b-1];
    if (PBITS == 1 && b == 9) return ^m_byte[i];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        m_active[i] = 1'b0;
        m_cnt[i]    = 0;
      end else if (!m_active[i]) begin
        if (tx_valid) begin
          m_active[i] = 1'b1;
          m_cnt[i]    = 0;
          m_byte[i]   = tx_data;
        end
      end else if (baud_tick) begin
        m_cnt[i]++;
        if (m_cnt[i] == frame_ticks(i)) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx[%0d]", i), 32'(tx_v[i]), 32'(exp_tx(i)));
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_active[i]));
      check($sformatf("tx_ready[%0d]", i), 32'(tx_ready_v[i]), 32'(!m_active[i]));
      check($sformatf("frame_done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit tick);
    baud_tick = tick;
    @(negedge clk);
  endtask

  task automatic drain();
    tx_valid = 1'b0;
    for (int k = 0; k < 600 && busy_v != 2'b00; k++) step(1'b1);
    check("drain_idle", 32'(busy_v), 32'h0);
  endtask

  logic lit[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int ticks, da, db, nda, ndb;
    bit after_first;

    // Reset, with tx_valid asserted to show it is ignored while rst=1.
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    step(1'b1); step(1'b1); step(1'b0);
    check("rst_tx", 32'(tx_v), 32'h3);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_ready", 32'(tx_ready_v), 32'h3);
    check("rst_done", 32'(done_v), 32'h0);
    tx_valid = 1'b0;
    rst = 1'b0;
    step(1'b0);

    // 0xA5 with baud_tick every 54 clk; tick on handshake edge must not count.
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    step(1'b1);
    tx_valid = 1'b0;
    tx_data = 8'h00;
    check("a5_start_low", 32'(tx_v), 32'h0);
    check("a5_busy", 32'(busy_v), 32'h3);
    ticks = 0; da = -1; db = -1; nda = 0; ndb = 0;
    for (int s = 1; s <= 8700; s++) begin
      bit t;
      t = (s % 54 == 0);
      step(t);
      if (t) begin
        ticks++;
        if (ticks % 16 == 8 && ticks < 160) check("a5_bit_a", 32'(tx_v[0]), 32'(lit[ticks/16]));
        if (ticks % 8 == 4 && ticks < 88) check("a5_bit_b", 32'(tx_v[1]), 32'(lit[ticks/8]));
      end
      if (done_v[0]) begin nda++; da = s; end
      if (done_v[1]) begin ndb++; db = s; end
    end
    check("a5_done_clk_a", 32'(da), 32'd8640);
    check("a5_done_clk_b", 32'(db), 32'd4752);
    check("a5_done_count_a", 32'(nda), 32'd1);
    check("a5_done_count_b", 32'(ndb), 32'd1);
    check("a5_ready_after", 32'(tx_ready_v), 32'h3);

    // 0xFF with a tick every clk: 160 ticks (16x,1 stop) and 88 ticks (8x,2 stop).
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    step(1'b0);
    tx_valid = 1'b0;
    da = -1; db = -1;
    for (int s = 1; s <= 200; s++) begin
      step(1'b1);
      if (done_v[0]) da = s;
      if (done_v[1]) db = s;
    end
    check("ff_done_tick_a", 32'(da), 32'd160);
    check("ff_done_tick_b", 32'(db), 32'd88);

    // Back-to-back: tx_valid held, data changes mid-frame; exactly one idle clk.
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    step(1'b0);
    nda = 0;
    after_first = 1'b0;
    for (int s = 1; s <= 400 && nda < 2; s++) begin
      if (s == 20) tx_data = 8'hC3;
      step(1'b1);
      if (after_first) begin
        check("b2b_rehandshake_busy", 32'(busy_v[0]), 32'h1);
        check("b2b_rehandshake_ready", 32'(tx_ready_v[0]), 32'h0);
        after_first = 1'b0;
      end
      if (done_v[0]) begin
        nda++;
        if (nda == 1) begin
          check("b2b_ready_on_done", 32'(tx_ready_v[0]), 32'h1);
          after_first = 1'b1;
        end
        if (nda == 2) tx_valid = 1'b0;
      end
    end
    check("b2b_frames_a", 32'(nda), 32'd2);
    drain();

    // Reset during data bit 3 of instance A aborts the frame.
    tx_valid = 1'b1;
    tx_data = 8'hE7;
    step(1'b0);
    tx_valid = 1'b0;
    for (int s = 0; s < 69; s++) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("abort_tx", 32'(tx_v), 32'h3);
    check("abort_busy", 32'(busy_v), 32'h0);
    check("abort_done", 32'(done_v), 32'h0);
    step(1'b1);
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    step(1'b0);
    tx_valid = 1'b0;
    nda = 0;
    for (int s = 1; s <= 170; s++) begin
      step(1'b1);
      if (done_v[0]) nda++;
    end
    check("abort_clean_frame", 32'(nda), 32'd1);

    // Freeze baud_tick for 1000 clk mid-frame, then the exact remainder completes.
    tx_valid = 1'b1;
    tx_data = 8'h0F;
    step(1'b0);
    tx_valid = 1'b0;
    for (int s = 0; s < 40; s++) step(1'b1);
    for (int s = 0; s < 1000; s++) step(1'b0);
    check("freeze_tx", 32'(tx_v), 32'h1);
    check("freeze_busy", 32'(busy_v), 32'h3);
    da = -1; db = -1;
    for (int s = 1; s <= 200; s++) begin
      step(1'b1);
      if (done_v[0]) da = s;
      if (done_v[1]) db = s;
    end
    check("freeze_rest_a", 32'(da), 32'd120);
    check("freeze_rest_b", 32'(db), 32'd48);

    // Randomized traffic: tick density, valid, data and occasional reset.
    for (int s = 0; s < 40000; s++) begin
      int dens;
      dens = (s / 4000) % 4 + 1;
      tx_valid = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 1999) == 0);
      step($urandom_range(1, dens) == 1);
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
